// File: rtl/clint_timer.sv
// Machine timer: 64-bit prescaled mtime and mtimecmp behind a single-outstanding MMIO port.
// Two cycles minimum per transaction; responses are held until resp_ready_i; timer_int_o lags the registers by one cycle.
module clint_timer #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wen_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   input  logic [7:0]  req_wmask_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [63:0] resp_rdata_o,
   output logic        addr_hit_o,
   output logic        timer_int_o
);

   localparam logic [63:0] MTIMECMP_ADDR = BASE_ADDR + 64'h4000;
   localparam logic [63:0] MTIME_ADDR    = BASE_ADDR + 64'hBFF8;
   localparam int          PW            = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic [63:0]   rdata_q, rdata_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          int_q, int_d;

   logic          hit_cmp, hit_time, accept, tick;
   logic [63:0]   mtime_inc, bmask;
   logic          unused_addr_lsb;

   assign hit_cmp         = (req_addr_i[63:3] == MTIMECMP_ADDR[63:3]);
   assign hit_time        = (req_addr_i[63:3] == MTIME_ADDR[63:3]);
   assign addr_hit_o      = hit_cmp | hit_time;
   assign unused_addr_lsb = ^req_addr_i[2:0];

   assign req_ready_o  = (state_q == IDLE);
   assign resp_valid_o = (state_q == RESP);
   assign resp_rdata_o = rdata_q;
   assign timer_int_o  = int_q;

   assign accept    = req_valid_i & req_ready_o;
   assign tick      = (presc_q == PRESC_MAX);
   assign mtime_inc = tick ? mtime_q + 64'd1 : mtime_q;

   always_comb begin
      bmask = '0;
      for (int b = 0; b < 8; b++) begin
         bmask[8*b +: 8] = {8{req_wmask_i[b]}};
      end
   end

   always_comb begin
      state_d    = state_q;
      mtime_d    = mtime_inc;
      mtimecmp_d = mtimecmp_q;
      rdata_d    = rdata_q;
      presc_d    = tick ? '0 : presc_q + 1'b1;
      int_d      = (mtime_q >= mtimecmp_q);

      if (accept) begin
         state_d = RESP;
         rdata_d = '0;
         if (req_wen_i) begin
            // Unwritten mtime bytes still pick up this edge's increment.
            if (hit_time) mtime_d    = (mtime_inc & ~bmask) | (req_wdata_i & bmask);
            if (hit_cmp)  mtimecmp_d = (mtimecmp_q & ~bmask) | (req_wdata_i & bmask);
         end else if (hit_time) begin
            rdata_d = mtime_q;
         end else if (hit_cmp) begin
            rdata_d = mtimecmp_q;
         end
      end else if ((state_q == RESP) && resp_ready_i) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         rdata_q    <= '0;
         presc_q    <= '0;
         int_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         rdata_q    <= rdata_d;
         presc_q    <= presc_d;
         int_q      <= int_d;
      end
   end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 1 and 4) sharing request fields,
// checked against an arithmetic model of mtime (anchor value + elapsed ticks) and mtimecmp.
module tb_clint_timer;

   localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
   localparam logic [63:0] A_CMP  = BASE + 64'h4000;
   localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
   localparam logic [63:0] A_UNM  = BASE + 64'h8000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic        req_wen = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wmask = '0;
   logic        resp_ready = 1'b1;
   logic [1:0]  req_ready, resp_valid, addr_hit, timer_int;
   logic [63:0] rdata [2];

   int checks = 0;
   int failures = 0;

   longint unsigned edges = 0;
   longint unsigned tdiv [2] = '{64'd1, 64'd4};
   logic [63:0]     anc_val [2];
   longint unsigned anc_e [2];
   logic [63:0]     cmp_m [2];

   always #5 clk = ~clk;

   always @(posedge clk) edges <= rst_n ? edges + 1 : 0;

   clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_div1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_wen_i(req_wen),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
      .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready), .resp_rdata_o(rdata[0]),
      .addr_hit_o(addr_hit[0]), .timer_int_o(timer_int[0])
   );

   clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_div4 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_wen_i(req_wen),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
      .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready), .resp_rdata_o(rdata[1]),
      .addr_hit_o(addr_hit[1]), .timer_int_o(timer_int[1])
   );

   // mtime after edge e: last written value plus the increment edges elapsed since.
   function automatic logic [63:0] mt(input int d, input longint unsigned e);
      return anc_val[d] + 64'(e / tdiv[d] - anc_e[d] / tdiv[d]);
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                         input logic [7:0] m);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic exp_int(input int d);
      return mt(d, edges - 1) >= cmp_m[d];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      resp_ready = 1'b1;
      step();
      step();
      for (int d = 0; d < 2; d++) begin
         anc_val[d] = '0;
         anc_e[d]   = 0;
         cmp_m[d]   = '1;
         check("rst_req_ready", 64'(req_ready[d]), 64'd1);
         check("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
         check("rst_rdata", rdata[d], 64'd0);
         check("rst_timer_int", 64'(timer_int[d]), 64'd0);
      end
      rst_n = 1'b1;
   endtask

   // One full transaction; hold = cycles resp_ready stays low after the response appears.
   task automatic xact(input int d, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [7:0] m, input int hold,
                       output logic [63:0] rd, output longint unsigned acc,
                       output logic int_acc);
      int n;
      logic [63:0] exp_rd;
      logic h_t, h_c;
      h_t = (addr[63:3] == A_TIME[63:3]);
      h_c = (addr[63:3] == A_CMP[63:3]);
      req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = m;
      resp_ready = (hold == 0);
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("req_ready_wait", 64'(req_ready[d]), 64'd1);
      req_valid[d] = 1'b1;
      step();
      acc = edges;
      int_acc = timer_int[d];
      req_valid[d] = 1'b0;
      exp_rd = '0;
      if (!wen && h_t) exp_rd = mt(d, acc - 1);
      else if (!wen && h_c) exp_rd = cmp_m[d];
      if (wen && h_t) begin
         anc_val[d] = merge(mt(d, acc), wd, m);
         anc_e[d]   = acc;
      end
      if (wen && h_c) cmp_m[d] = merge(cmp_m[d], wd, m);
      check("resp_valid", 64'(resp_valid[d]), 64'd1);
      check("rdata", rdata[d], exp_rd);
      rd = rdata[d];
      for (int i = 0; i < hold; i++) begin
         step();
         check("hold_valid", 64'(resp_valid[d]), 64'd1);
         check("hold_rdata", rdata[d], rd);
         check("hold_req_ready", 64'(req_ready[d]), 64'd0);
      end
      resp_ready = 1'b1;
      step();
      check("resp_done", 64'(resp_valid[d]), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0]     rd, wd;
      longint unsigned acc;
      logic            ia;
      int              d, op, gap, hold;
      logic [7:0]      m;

      do_reset();

      // Free-running mtime after reset, interrupt idle with mtimecmp all ones.
      repeat (3) step();
      xact(0, 1'b0, A_TIME, '0, '0, 0, rd, acc, ia);
      check("mtime_since_reset", rd, 64'(acc - 1));
      check("int_idle", 64'(timer_int[0]), 64'd0);

      // Compare at 0x20: track the level every cycle across the crossing.
      xact(0, 1'b1, A_CMP, 64'h20, 8'hFF, 0, rd, acc, ia);
      for (int i = 0; i < 50; i++) begin
         check("int_rise_track", 64'(timer_int[0]), 64'(exp_int(0)));
         step();
      end
      xact(0, 1'b1, A_CMP, 64'hFFFF, 8'hFF, 0, rd, acc, ia);
      check("int_before_raise", 64'(ia), 64'd1);
      check("int_after_raise", 64'(timer_int[0]), 64'd0);

      // Wrap of mtime through 2^64-1.
      xact(0, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd, acc, ia);
      for (int i = 0; i < 4; i++) begin
         check("int_wrap_track", 64'(timer_int[0]), 64'(exp_int(0)));
         step();
      end
      xact(0, 1'b0, A_TIME, '0, '0, 0, rd, acc, ia);
      check("mtime_wrapped_small", 64'(rd < 64'h10), 64'd1);

      // Partial byte-masked write of mtimecmp.
      xact(0, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd, acc, ia);
      xact(0, 1'b1, A_CMP, 64'h1111_2222_3333_4444, 8'h0F, 0, rd, acc, ia);
      xact(0, 1'b0, A_CMP, '0, '0, 0, rd, acc, ia);
      check("masked_cmp", rd, 64'hFFFF_FFFF_3333_4444);

      // Address decode, ignoring the byte offset.
      req_addr = A_CMP + 64'd3;  #1 check("hit_cmp", 64'(addr_hit[0]), 64'd1);
      req_addr = A_TIME + 64'd7; #1 check("hit_time", 64'(addr_hit[0]), 64'd1);
      req_addr = A_UNM;          #1 check("hit_unm", 64'(addr_hit[0]), 64'd0);
      req_addr = A_CMP + 64'd8;  #1 check("hit_cmp_next", 64'(addr_hit[0]), 64'd0);

      // Backpressure: a second request waits while the response is stalled.
      resp_ready = 1'b0;
      req_wen = 1'b0; req_addr = A_CMP; req_valid[0] = 1'b1;
      step();
      req_addr = A_UNM;
      check("bp_valid", 64'(resp_valid[0]), 64'd1);
      check("bp_rdata", rdata[0], cmp_m[0]);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_valid", 64'(resp_valid[0]), 64'd1);
         check("bp_hold_rdata", rdata[0], cmp_m[0]);
         check("bp_hold_ready", 64'(req_ready[0]), 64'd0);
      end
      resp_ready = 1'b1;
      step();
      check("bp_released_valid", 64'(resp_valid[0]), 64'd0);
      check("bp_released_ready", 64'(req_ready[0]), 64'd1);
      step();
      req_valid[0] = 1'b0;
      check("bp_second_valid", 64'(resp_valid[0]), 64'd1);
      check("unmapped_read", rdata[0], 64'd0);
      step();

      // Unmapped write leaves mtimecmp alone.
      xact(0, 1'b1, A_CMP + 64'd8, 64'h0, 8'hFF, 0, rd, acc, ia);
      xact(0, 1'b0, A_CMP, '0, '0, 0, rd, acc, ia);
      check("unmapped_write_ignored", rd, 64'hFFFF_FFFF_3333_4444);

      // Divided timer: read twice, then a byte-0 write on an increment edge.
      xact(1, 1'b0, A_TIME, '0, '0, 0, rd, acc, ia);
      repeat (7) step();
      xact(1, 1'b0, A_TIME, '0, '0, 0, rd, acc, ia);
      while ((edges + 1) % 4 != 0) step();
      xact(1, 1'b1, A_TIME, 64'h1FF, 8'hFF, 0, rd, acc, ia);
      while ((edges + 1) % 4 != 0) step();
      wd = {$urandom, $urandom};
      xact(1, 1'b1, A_TIME, wd, 8'h01, 0, rd, acc, ia);
      xact(1, 1'b0, A_TIME, '0, '0, 0, rd, acc, ia);
      check("div4_inc_edge_write", rd, {56'h2, wd[7:0]});

      // Randomized traffic on both instances.
      for (int it = 0; it < 40; it++) begin
         d    = int'($urandom_range(0, 1));
         op   = int'($urandom_range(0, 4));
         hold = int'($urandom_range(0, 3));
         gap  = int'($urandom_range(0, 5));
         wd   = {$urandom, $urandom};
         m    = 8'($urandom);
         case (op)
            0: xact(d, 1'b1, A_CMP, wd, m, hold, rd, acc, ia);
            1: xact(d, 1'b0, A_CMP + 64'($urandom_range(0, 7)), '0, '0, hold, rd, acc, ia);
            2: xact(d, 1'b0, A_TIME + 64'($urandom_range(0, 7)), '0, '0, hold, rd, acc, ia);
            3: xact(d, 1'($urandom_range(0, 1)), A_UNM, wd, m, hold, rd, acc, ia);
            default: xact(d, 1'b1, A_TIME, wd, m, hold, rd, acc, ia);
         endcase
         check("rand_int", 64'(timer_int[d]), 64'(exp_int(d)));
         for (int g = 0; g < gap; g++) step();
      end

      // Reset in the middle of a stalled transaction drops it.
      resp_ready = 1'b0;
      req_wen = 1'b0; req_addr = A_TIME; req_valid[0] = 1'b1;
      step();
      check("mid_valid", 64'(resp_valid[0]), 64'd1);
      do_reset();
      step();
      xact(0, 1'b0, A_CMP, '0, '0, 0, rd, acc, ia);
      check("post_reset_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
      xact(0, 1'b0, A_TIME, '0, '0, 0, rd, acc, ia);
      xact(1, 1'b0, A_TIME, '0, '0, 0, rd, acc, ia);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
